generador_fecha: RTL and testbench

- Calendar date generator that sits directly upstream of the day/month comparator stage.
- Produces the running day (dia, 5 bit) and month (mes, 4 bit) that feed the comparator's dia/mes inputs; the comparator's diaRef/mesRef are driven elsewhere.
- Advances one day every CICLOS_POR_DIA enabled clock cycles, honours month lengths and leap years, and supports validated date loading.
- Emits a one-cycle strobe whenever the date changes, so the downstream compare result is sampled only on fresh dates.

---
 rtl/generador_fecha.sv | 95 +++++++++
 tb/tb_generador_fecha.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/generador_fecha.sv
// Calendar day/month generator feeding the day/month comparator.
// Advances one day every CICLOS_POR_DIA enabled cycles; supports validated loads.
module generador_fecha #(
   parameter int CICLOS_POR_DIA = 4,
   parameter int PW = (CICLOS_POR_DIA > 1) ? $clog2(CICLOS_POR_DIA) : 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic       carga,
   input  logic [4:0] dia_in,
   input  logic [3:0] mes_in,
   input  logic       bisiesto,
   output logic [4:0] dia,
   output logic [3:0] mes,
   output logic       nuevo_dia,
   output logic       fin_anio,
   output logic       error_carga
);

   localparam logic [PW-1:0] ULTIMO = PW'(CICLOS_POR_DIA - 1);

   function automatic logic [4:0] largo_mes(input logic [3:0] m, input logic b);
      case (m)
         4'd2:                    largo_mes = b ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: largo_mes = 5'd30;
         default:                 largo_mes = 5'd31;
      endcase
   endfunction

   logic [PW-1:0] pre, pre_d;
   logic [4:0]    dia_d;
   logic [3:0]    mes_d;
   logic          nuevo_d, fin_d, err_d;
   logic          carga_ok, tic;

   always_comb begin
      carga_ok = (mes_in >= 4'd1) && (mes_in <= 4'd12) && (dia_in != 5'd0) &&
                 (dia_in <= largo_mes(mes_in, bisiesto));
      tic      = en && !carga && (pre == ULTIMO);
      dia_d    = dia;
      mes_d    = mes;
      pre_d    = pre;
      nuevo_d  = 1'b0;
      fin_d    = 1'b0;
      err_d    = 1'b0;
      if (carga) begin
         // Load wins over advance; a rejected load leaves the prescaler untouched.
         if (carga_ok) begin
            dia_d   = dia_in;
            mes_d   = mes_in;
            pre_d   = '0;
            nuevo_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end else if (en) begin
         pre_d = tic ? '0 : pre + PW'(1);
         if (tic) begin
            nuevo_d = 1'b1;
            // >= so a Feb 29 left over after bisiesto drops still rolls to 1 Mar
            if (dia >= largo_mes(mes, bisiesto)) begin
               dia_d = 5'd1;
               if (mes == 4'd12) begin
                  mes_d = 4'd1;
                  fin_d = 1'b1;
               end else begin
                  mes_d = mes + 4'd1;
               end
            end else begin
               dia_d = dia + 5'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dia         <= 5'd1;
         mes         <= 4'd1;
         pre         <= '0;
         nuevo_dia   <= 1'b0;
         fin_anio    <= 1'b0;
         error_carga <= 1'b0;
      end else begin
         dia         <= dia_d;
         mes         <= mes_d;
         pre         <= pre_d;
         nuevo_dia   <= nuevo_d;
         fin_anio    <= fin_d;
         error_carga <= err_d;
      end
   end

endmodule

// File: tb/tb_generador_fecha.sv
// Randomized bench for generador_fecha against a calendar reference model.
module tb_generador_fecha;

   localparam int C = 4;

   logic       clk, reset_n, en, carga, bisiesto;
   logic [4:0] dia_in, dia;
   logic [3:0] mes_in, mes;
   logic       nuevo_dia, fin_anio, error_carga;

   generador_fecha #(.CICLOS_POR_DIA(C)) u_dut (
      .clk(clk), .reset_n(reset_n), .en(en), .carga(carga),
      .dia_in(dia_in), .mes_in(mes_in), .bisiesto(bisiesto),
      .dia(dia), .mes(mes), .nuevo_dia(nuevo_dia),
      .fin_anio(fin_anio), .error_carga(error_carga)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int dias_mes[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

   // reference state
   int md = 1, mm = 1, pc = 0;
   bit e_nuevo = 0, e_fin = 0, e_err = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int mlen(input int m, input bit b);
      if (m < 1 || m > 12) return 0;
      return (m == 2 && b) ? 29 : dias_mes[m];
   endfunction

   task automatic check_outs();
      chk("dia", int'(dia), md);
      chk("mes", int'(mes), mm);
      chk("nuevo_dia", int'(nuevo_dia), int'(e_nuevo));
      chk("fin_anio", int'(fin_anio), int'(e_fin));
      chk("error_carga", int'(error_carga), int'(e_err));
   endtask

   // One clock edge: drive inputs, update model, sample #1 after the edge.
   task automatic step(input bit e, input bit c, input int di, input int mi, input bit b);
      en = e; carga = c; dia_in = 5'(di); mes_in = 4'(mi); bisiesto = b;
      e_nuevo = 0; e_fin = 0; e_err = 0;
      if (c) begin
         if (mi >= 1 && mi <= 12 && di >= 1 && di <= mlen(mi, b)) begin
            md = di; mm = mi; pc = 0; e_nuevo = 1;
         end else begin
            e_err = 1;
         end
      end else if (e) begin
         pc++;
         if (pc == C) begin
            pc = 0;
            e_nuevo = 1;
            if (md >= mlen(mm, b)) begin
               md = 1;
               if (mm == 12) begin mm = 1; e_fin = 1; end
               else mm++;
            end else begin
               md++;
            end
         end
      end
      @(posedge clk); #1;
      check_outs();
   endtask

   task automatic reset_mid();
      #2 reset_n = 1'b0;
      #1;
      md = 1; mm = 1; pc = 0; e_nuevo = 0; e_fin = 0; e_err = 0;
      check_outs();
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; en = 0; carga = 0; dia_in = '0; mes_in = '0; bisiesto = 0;
      repeat (3) @(posedge clk);
      #1;
      check_outs();
      reset_n = 1'b1;

      repeat (10) step(0, 0, 0, 0, 0);

      // 31/1, advance with an en gap mid-count
      step(0, 1, 31, 1, 0);
      repeat (2) step(1, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0, 0);
      chk("adv_to_1_2", int'(mes), 2);

      // February, non-leap then leap
      step(0, 1, 28, 2, 0);
      repeat (4) step(1, 0, 0, 0, 0);
      step(0, 1, 28, 2, 1);
      repeat (8) step(1, 0, 0, 0, 1);

      // year rollover
      step(0, 1, 31, 12, 0);
      repeat (4) step(1, 0, 0, 0, 0);
      chk("fin_anio_dec31", int'(fin_anio), 1);

      // invalid loads from 10/6 with prescaler at 2
      step(0, 1, 10, 6, 0);
      repeat (2) step(1, 0, 0, 0, 0);
      step(1, 1, 31, 4, 0);
      step(1, 1, 30, 2, 0);
      step(1, 1, 0, 5, 0);
      step(1, 1, 15, 13, 0);
      repeat (2) step(1, 0, 0, 0, 0);
      chk("prescaler_kept", int'(dia), 11);

      // load on terminal count
      step(0, 1, 1, 1, 0);
      repeat (3) step(1, 0, 0, 0, 0);
      step(1, 1, 5, 5, 0);
      repeat (4) step(1, 0, 0, 0, 0);

      // async reset with prescaler at 2, and during a pulse
      repeat (2) step(1, 0, 0, 0, 0);
      reset_mid();
      step(0, 1, 7, 7, 0);
      reset_mid();
      repeat (C) step(1, 0, 0, 0, 0);

      // randomized traffic
      begin
         bit b = 0;
         for (int i = 0; i < 3000; i++) begin
            bit e, c;
            int di, mi;
            if ($urandom_range(49) == 0) b = ~b;
            e = ($urandom_range(3) != 0);
            c = ($urandom_range(11) == 0);
            if ($urandom_range(1) == 0) begin
               mi = $urandom_range(12, 1);
               di = $urandom_range(mlen(mi, b), 1);
            end else begin
               mi = $urandom_range(15);
               di = $urandom_range(31);
            end
            step(e, c, di, mi, b);
            if ($urandom_range(499) == 0) reset_mid();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
